// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer write arbiter: FSM state and pixel word.
package fb_arb_pkg;

  typedef enum logic {ST_CLEAR, ST_ARB} fb_arb_state_t;

  typedef logic [23:0] pixel_t;

endpackage

// File: rtl/fb_write_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N. Returns both a one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  int idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    // Scan from the farthest offset down so the nearest valid offset wins.
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (req_i[IW'(idx)]) begin
        any_o     = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
    if (any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port among NREQ producers (round-robin) and
// owns a clear engine that floods the whole framebuffer with one colour.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int     NREQ         = 3,
  parameter int     FB_PIXELS    = 921600,
  parameter int     FB_ADDR_BITS = 20,
  parameter int     AUTO_CLEAR   = 1,
  parameter pixel_t CLEAR_COLOR  = 24'h0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NREQ-1:0]              req_valid_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic [NREQ*FB_ADDR_BITS-1:0] req_addr_i,
  input  logic [NREQ*24-1:0]           req_data_i,
  input  logic                         clear_start_i,
  input  logic [23:0]                  clear_color_i,
  output logic                         busy_o,
  output logic                         clear_done_o,
  output logic                         addr_err_o,
  output logic [FB_ADDR_BITS-1:0]      pxl_addr_o,
  output logic [23:0]                  pxl_data_o,
  output logic                         pxl_en_o
);

  localparam int IW = $clog2(NREQ);
  localparam logic [FB_ADDR_BITS-1:0] LAST_ADDR = FB_ADDR_BITS'(FB_PIXELS - 1);
  localparam logic [FB_ADDR_BITS:0]   PIX_LIMIT = (FB_ADDR_BITS + 1)'(FB_PIXELS);
  localparam fb_arb_state_t RST_STATE = (AUTO_CLEAR != 0) ? ST_CLEAR : ST_ARB;

  logic [FB_ADDR_BITS-1:0] addr_arr [NREQ];
  pixel_t                  data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr_i[gi*FB_ADDR_BITS +: FB_ADDR_BITS];
    assign data_arr[gi] = req_data_i[gi*24 +: 24];
  end

  fb_arb_state_t           state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [FB_ADDR_BITS-1:0] cnt_q, cnt_d;
  pixel_t                  color_q, color_d;
  logic                    pxl_en_q, pxl_en_d;
  logic [FB_ADDR_BITS-1:0] pxl_addr_q, pxl_addr_d;
  pixel_t                  pxl_data_q, pxl_data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [NREQ-1:0]         gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    gnt_any;
  logic                    arb_open;
  logic [FB_ADDR_BITS-1:0] sel_addr;
  pixel_t                  sel_data;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // A pending clear command steals the cycle from every requester.
  assign arb_open    = (state_q == ST_ARB) && !clear_start_i;
  assign req_ready_o = arb_open ? gnt : '0;
  assign sel_addr    = addr_arr[gnt_idx];
  assign sel_data    = data_arr[gnt_idx];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    pxl_en_d   = 1'b0;
    pxl_addr_d = pxl_addr_q;
    pxl_data_d = pxl_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        pxl_en_d   = 1'b1;
        pxl_addr_d = cnt_q;
        pxl_data_d = color_q;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_ARB;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (clear_start_i) begin
          color_d = clear_color_i;
          state_d = ST_CLEAR;
        end else if (gnt_any) begin
          ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          // Out-of-range writes complete the handshake but never reach memory.
          if ({1'b0, sel_addr} < PIX_LIMIT) begin
            pxl_en_d   = 1'b1;
            pxl_addr_d = sel_addr;
            pxl_data_d = sel_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= RST_STATE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      color_q    <= CLEAR_COLOR;
      pxl_en_q   <= 1'b0;
      pxl_addr_q <= '0;
      pxl_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      pxl_en_q   <= pxl_en_d;
      pxl_addr_q <= pxl_addr_d;
      pxl_data_q <= pxl_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy_o       = (state_q == ST_CLEAR);
  assign clear_done_o = done_q;
  assign addr_err_o   = err_q;
  assign pxl_en_o     = pxl_en_q;
  assign pxl_addr_o   = pxl_addr_q;
  assign pxl_data_o   = pxl_data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios then random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_fb_write_arbiter;

  localparam int          NREQ = 3;
  localparam int          FB_PIXELS = 16;
  localparam int          AB = 5;
  localparam logic [23:0] CLR = 24'h3C5A7E;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AB-1:0]   req_addr;
  logic [NREQ*24-1:0]   req_data;
  logic                 clear_start;
  logic [23:0]          clear_color;
  logic                 busy, done, err, pxl_en;
  logic [AB-1:0]        pxl_addr;
  logic [23:0]          pxl_data;

  fb_write_arbiter #(
    .NREQ(NREQ), .FB_PIXELS(FB_PIXELS), .FB_ADDR_BITS(AB),
    .AUTO_CLEAR(1), .CLEAR_COLOR(CLR)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .clear_start_i(clear_start), .clear_color_i(clear_color),
    .busy_o(busy), .clear_done_o(done), .addr_err_o(err),
    .pxl_addr_o(pxl_addr), .pxl_data_o(pxl_data), .pxl_en_o(pxl_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: "clearing" with a remaining-pixel index, or arbitrating.
  bit          m_clearing;
  int          m_idx;
  logic [23:0] m_color;
  int          m_ptr;
  bit          e_en, e_done, e_err;
  int          e_addr;
  logic [23:0] e_data;

  logic [NREQ-1:0] last_ready;
  int              obs_grant;
  int              done_count;
  int              write_count;

  function automatic bit valid_of(input int r);
    return req_valid[r +: 1];
  endfunction

  function automatic int model_grant();
    if (m_clearing || clear_start) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int r;
      r = (m_ptr + k) % NREQ;
      if (valid_of(r)) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_clearing = 1'b1; m_idx = 0; m_color = CLR; m_ptr = 0;
    e_en = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = '0;
  endtask

  task automatic model_update();
    int g;
    g = model_grant();
    e_en = 0; e_done = 0; e_err = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_clearing) begin
      e_en = 1; e_addr = m_idx; e_data = m_color;
      if (m_idx == FB_PIXELS - 1) begin
        e_done = 1; m_clearing = 0; m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (clear_start) begin
      m_color = clear_color; m_clearing = 1;
    end else if (g >= 0) begin
      int a;
      a = int'(req_addr[g*AB +: AB]);
      m_ptr = (g + 1) % NREQ;
      if (a < FB_PIXELS) begin
        e_en = 1; e_addr = a; e_data = req_data[g*24 +: 24];
      end else begin
        e_err = 1;
      end
    end
  endtask

  // One clock: check ready against the model, advance, then check outputs.
  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g +: 1] = 1'b1;
    last_ready = req_ready;
    obs_grant = -1;
    for (int r = 0; r < NREQ; r++) if (last_ready[r +: 1]) obs_grant = r;
    check("req_ready", req_ready, exp_ready);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("pxl_en", pxl_en, e_en);
    check("pxl_addr", pxl_addr, e_addr);
    check("pxl_data", pxl_data, e_data);
    check("clear_done", done, e_done);
    check("addr_err", err, e_err);
    check("busy", busy, m_clearing);
    if (done === 1'b1) done_count++;
    if (pxl_en === 1'b1) write_count++;
  endtask

  task automatic set_req(input int r, input int a, input logic [23:0] d);
    req_addr[r*AB +: AB] = AB'(a);
    req_data[r*24 +: 24] = d;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    clear_start = 1'b0; clear_color = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();

    // Reset-triggered clear
    rst_n = 1'b1; done_count = 0; write_count = 0;
    repeat (17) tick();
    check("auto_clear_writes", write_count, 16);
    check("auto_clear_done", done_count, 1);

    // All requesters valid: strict rotation from pointer 0
    req_valid = '1;
    for (int r = 0; r < NREQ; r++) set_req(r, r + 1, 24'h111111 * (r + 1));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_sequence", obs_grant, i % NREQ);
      check("rr_follow_addr", pxl_addr, (i % NREQ) + 1);
    end

    // Lone requester 1
    req_valid = 3'b010; set_req(1, 5, 24'hABCDEF);
    tick();
    check("req1_ready", last_ready, 3'b010);
    check("req1_addr", pxl_addr, 5);
    check("req1_data", pxl_data, 24'hABCDEF);

    // Commanded clear preempts a waiting requester
    req_valid = 3'b001; set_req(0, 3, 24'h000777);
    clear_start = 1'b1; clear_color = 24'h00FF00;
    tick();
    check("clear_cmd_no_grant", last_ready, 3'b000);
    clear_start = 1'b0; done_count = 0; write_count = 0;
    repeat (16) tick();
    check("cmd_clear_writes", write_count, 16);
    check("cmd_clear_done", done_count, 1);
    check("cmd_clear_color", pxl_data, 24'h00FF00);
    tick();
    check("req0_after_clear", last_ready, 3'b001);

    // Out-of-range address from requester 2
    req_valid = 3'b100; set_req(2, 20, 24'h123123);
    tick();
    check("oor_ready", last_ready, 3'b100);
    check("oor_err", err, 1);
    check("oor_en", pxl_en, 0);
    req_valid = 3'b111;
    tick();
    check("ptr_after_oor", last_ready, 3'b001);
    req_valid = '0;

    // Reset in the middle of a clear restarts it from address 0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    done_count = 0; write_count = 0;
    repeat (17) tick();
    check("restart_clear_writes", write_count, 16);
    check("restart_clear_done", done_count, 1);

    // Random traffic; a stalled requester holds its address and data.
    for (int i = 0; i < 500; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!(req_valid[r +: 1] && !last_ready[r +: 1])) begin
          req_valid[r +: 1] = ($urandom_range(0, 99) < 60);
          set_req(r, int'($urandom_range(0, 31)), 24'($urandom));
        end
      end
      clear_start = ($urandom_range(0, 39) == 0);
      clear_color = 24'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
